// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - sub-word load/store controller with read-modify-write
// Bridges the core memory stage to the word-wide DataMemory.
module mem_access_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_valid,
    input  logic        cpu_write,
    input  logic [2:0]  cpu_funct3,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_done,
    output logic        cpu_err,
    output logic        cpu_stall,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_din,
    output logic        dm_mem_read,
    output logic        dm_mem_write,
    input  logic [31:0] dm_mem_out
);

    typedef enum logic [1:0] {IDLE, ACCESS, MERGE, DONE} state_t;

    state_t      state_q, state_d;
    logic        write_q, write_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] merge_q, merge_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        illegal;
    logic        misaligned;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;
    logic [31:0] merged;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            write_q  <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            merge_q  <= 32'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            merge_q  <= merge_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        illegal = 1'b0;
        if (cpu_write) begin
            illegal = !(cpu_funct3 == 3'b000 || cpu_funct3 == 3'b001 || cpu_funct3 == 3'b010);
        end else begin
            illegal = (cpu_funct3 == 3'b011 || cpu_funct3 == 3'b110 || cpu_funct3 == 3'b111);
        end
        // Word accesses need addr[1:0]==0, halfword accesses need addr[0]==0
        misaligned = ((cpu_funct3[1:0] == 2'b10) && (cpu_addr[1:0] != 2'b00)) ||
                     ((cpu_funct3[1:0] == 2'b01) && cpu_addr[0]);
    end

    always_comb begin
        ld_byte = dm_mem_out[{addr_q[1:0], 3'b000} +: 8];
        ld_half = dm_mem_out[{addr_q[1], 4'b0000} +: 16];
        case (funct3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'h0, ld_byte};
            3'b101:  ld_ext = {16'h0, ld_half};
            default: ld_ext = dm_mem_out;
        endcase
        merged = merge_q;
        if (funct3_q == 3'b000) begin
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
    end

    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        funct3_d     = funct3_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        merge_d      = merge_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        dm_addr      = 32'h0;
        dm_din       = 32'h0;
        dm_mem_read  = 1'b0;
        dm_mem_write = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_valid) begin
                    write_d  = cpu_write;
                    funct3_d = cpu_funct3;
                    addr_d   = cpu_addr;
                    wdata_d  = cpu_wdata;
                    err_d    = illegal | misaligned;
                    state_d  = (illegal | misaligned) ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                dm_addr = {addr_q[31:2], 2'b00};
                if (write_q && funct3_q == 3'b010) begin
                    dm_mem_write = 1'b1;
                    dm_din       = wdata_q;
                    state_d      = DONE;
                end else if (write_q) begin
                    dm_mem_read = 1'b1;
                    merge_d     = dm_mem_out;
                    state_d     = MERGE;
                end else begin
                    dm_mem_read = 1'b1;
                    rdata_d     = ld_ext;
                    state_d     = DONE;
                end
            end
            MERGE: begin
                dm_addr      = {addr_q[31:2], 2'b00};
                dm_mem_write = 1'b1;
                dm_din       = merged;
                state_d      = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign cpu_rdata = rdata_q;
    assign cpu_done  = (state_q == DONE);
    assign cpu_err   = (state_q == DONE) && err_q;
    assign cpu_stall = cpu_valid && !cpu_done;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit
// Directed requests push expectations; a monitor checks each completion.
module tb_mem_access_unit;

    logic        clk;
    logic        reset;
    logic        cpu_valid;
    logic        cpu_write;
    logic [2:0]  cpu_funct3;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_done;
    logic        cpu_err;
    logic        cpu_stall;
    logic [31:0] dm_addr;
    logic [31:0] dm_din;
    logic        dm_mem_read;
    logic        dm_mem_write;
    logic [31:0] dm_mem_out;

    mem_access_unit dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_valid    (cpu_valid),
        .cpu_write    (cpu_write),
        .cpu_funct3   (cpu_funct3),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_rdata    (cpu_rdata),
        .cpu_done     (cpu_done),
        .cpu_err      (cpu_err),
        .cpu_stall    (cpu_stall),
        .dm_addr      (dm_addr),
        .dm_din       (dm_din),
        .dm_mem_read  (dm_mem_read),
        .dm_mem_write (dm_mem_write),
        .dm_mem_out   (dm_mem_out)
    );

    typedef struct {
        int          id;
        int          done_cyc;
        logic        err;
        logic [31:0] rdata;
        int          rd_n;
        int          wr_n;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] mem [0:255];
    int          cyc;
    int          tests;
    int          fails;
    int          rd_cnt;
    int          wr_cnt;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    end

    assign dm_mem_out = mem[dm_addr[9:2]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (dm_mem_write) mem[dm_addr[9:2]] <= dm_din;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            rd_cnt = 0;
            wr_cnt = 0;
        end else begin
            if (dm_mem_read || dm_mem_write) begin
                chk("dm_addr_aligned", {30'h0, dm_addr[1:0]}, 32'h0);
                if (dm_mem_read) rd_cnt++;
                if (dm_mem_write) wr_cnt++;
            end
            if (cpu_done) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", 32'h1, 32'h0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    $display("[TB] check request %0d", e.id);
                    chk("done_cycle", cyc, e.done_cyc);
                    chk("cpu_err", {31'h0, cpu_err}, {31'h0, e.err});
                    chk("cpu_rdata", cpu_rdata, e.rdata);
                    chk("read_count", rd_cnt, e.rd_n);
                    chk("write_count", wr_cnt, e.wr_n);
                end
                rd_cnt = 0;
                wr_cnt = 0;
            end
        end
    end

    // Called at a negedge while the DUT is idle; returns at the next idle negedge.
    task automatic run(input int id, input logic w, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d, input logic e,
                       input logic [31:0] rd, input int lat, input int rdn, input int wrn);
        exp_t x;
        logic seen;
        x.id = id; x.done_cyc = cyc + lat; x.err = e; x.rdata = rd;
        x.rd_n = rdn; x.wr_n = wrn;
        sb_q.push_back(x);
        cpu_valid = 1'b1; cpu_write = w; cpu_funct3 = f3; cpu_addr = a; cpu_wdata = d;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (cpu_done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk("done_timeout", 32'h0, 32'h1);
        cpu_valid = 1'b0;
        cpu_wdata = 32'h0;
        @(negedge clk);
    endtask

    initial begin
        cyc = 0; tests = 0; fails = 0; rd_cnt = 0; wr_cnt = 0;
        reset = 1'b0;
        cpu_valid = 1'b0; cpu_write = 1'b0; cpu_funct3 = 3'b000;
        cpu_addr = 32'h0; cpu_wdata = 32'h0;

        for (int i = 0; i < 3; i++) begin
            cpu_valid  = 1'($urandom_range(0, 1));
            cpu_write  = 1'($urandom_range(0, 1));
            cpu_funct3 = 3'($urandom_range(0, 7));
            cpu_addr   = $urandom;
            cpu_wdata  = $urandom;
            @(negedge clk);
            chk("rst_rdata", cpu_rdata, 32'h0);
            chk("rst_done_err", {30'h0, cpu_done, cpu_err}, 32'h0);
            chk("rst_stall", {31'h0, cpu_stall}, {31'h0, cpu_valid});
            chk("rst_dm_addr_din", dm_addr | dm_din, 32'h0);
            chk("rst_dm_rw", {30'h0, dm_mem_read, dm_mem_write}, 32'h0);
        end
        cpu_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);

        run(1,  1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 1'b0, 32'h0,        2, 0, 1);
        chk("mem_after_sw", mem[8'h40], 32'hDEADBEEF);
        run(2,  1'b0, 3'b010, 32'h100, 32'h0,        1'b0, 32'hDEADBEEF, 2, 1, 0);
        run(3,  1'b1, 3'b000, 32'h101, 32'h000000AA, 1'b0, 32'hDEADBEEF, 3, 1, 1);
        chk("mem_after_sb", mem[8'h40], 32'hDEADAAEF);
        run(4,  1'b0, 3'b000, 32'h101, 32'h0,        1'b0, 32'hFFFFFFAA, 2, 1, 0);
        run(5,  1'b0, 3'b100, 32'h101, 32'h0,        1'b0, 32'h000000AA, 2, 1, 0);
        run(6,  1'b1, 3'b001, 32'h102, 32'h00001234, 1'b0, 32'h000000AA, 3, 1, 1);
        chk("mem_after_sh", mem[8'h40], 32'h1234AAEF);
        run(7,  1'b0, 3'b001, 32'h102, 32'h0,        1'b0, 32'h00001234, 2, 1, 0);
        run(8,  1'b0, 3'b001, 32'h100, 32'h0,        1'b0, 32'hFFFFAAEF, 2, 1, 0);
        run(9,  1'b0, 3'b101, 32'h100, 32'h0,        1'b0, 32'h0000AAEF, 2, 1, 0);
        run(10, 1'b0, 3'b000, 32'h103, 32'h0,        1'b0, 32'h00000012, 2, 1, 0);
        run(11, 1'b0, 3'b010, 32'h102, 32'h0,        1'b1, 32'h00000012, 1, 0, 0);
        run(12, 1'b1, 3'b001, 32'h103, 32'h0000FFFF, 1'b1, 32'h00000012, 1, 0, 0);
        run(13, 1'b0, 3'b011, 32'h100, 32'h0,        1'b1, 32'h00000012, 1, 0, 0);
        run(14, 1'b1, 3'b100, 32'h100, 32'h0,        1'b1, 32'h00000012, 1, 0, 0);
        chk("mem_after_errors", mem[8'h40], 32'h1234AAEF);

        cpu_valid = 1'b1; cpu_write = 1'b1; cpu_funct3 = 3'b000;
        cpu_addr = 32'h100; cpu_wdata = 32'h00000055;
        @(negedge clk);
        @(negedge clk);
        chk("merge_write", {31'h0, dm_mem_write}, 32'h1);
        chk("merge_din", dm_din, 32'h1234AA55);
        reset = 1'b0;
        #1;
        chk("rst_drops_write", {31'h0, dm_mem_write}, 32'h0);
        chk("rst_no_done", {31'h0, cpu_done}, 32'h0);
        cpu_valid = 1'b0;
        @(negedge clk);
        chk("mem_after_abort", mem[8'h40], 32'h1234AAEF);
        chk("rdata_after_rst", cpu_rdata, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        run(15, 1'b0, 3'b010, 32'h100, 32'h0,        1'b0, 32'h1234AAEF, 2, 1, 0);

        chk("scoreboard_empty", sb_q.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
